// File: rtl/pcie_dest_drain.sv
// pcie_dest_drain
//   Drains the two destination FIFOs (D0, D1) and presents the words to a
//   single sink over a valid/ready handshake. D0 and D1 are served round-robin
//   on ties, and a FIFO is never popped while its empty flag is set.
//   Pop in cycle N, FIFO data in N+1 (FETCH), valid_sink from N+2 (HOLD).
//
// Optional feature macro: DRAIN_COUNT_EN
//   defined   -> CNT_W parameter, cnt_D0/cnt_D1 ports and counters present
//   undefined -> counters removed; init only resets the round-robin pointer
//
// Ports:
//   clk, reset_L (async, active-low), init (sync clear of counters/pointer)
//   empty_D0/empty_D1, data_out0/data_out1 : FIFO status and read data
//   sink_ready                             : sink accepts data_sink
//   pop_D0/pop_D1                          : combinational FIFO pops
//   data_sink/valid_sink/dest_sink         : registered output word, source
//   idle_drain                             : IDLE with both FIFOs empty
//   cnt_D0/cnt_D1                          : words delivered per destination
module pcie_dest_drain #(
  parameter int DATA_W = 6
`ifdef DRAIN_COUNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic              empty_D0,
  input  logic              empty_D1,
  input  logic [DATA_W-1:0] data_out0,
  input  logic [DATA_W-1:0] data_out1,
  input  logic              sink_ready,
  output logic              pop_D0,
  output logic              pop_D1,
  output logic [DATA_W-1:0] data_sink,
  output logic              valid_sink,
  output logic              dest_sink,
  output logic              idle_drain
`ifdef DRAIN_COUNT_EN
  , output logic [CNT_W-1:0] cnt_D0
  , output logic [CNT_W-1:0] cnt_D1
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;   // last-served destination (1 = D1)
  logic              sel_q, sel_d;     // destination popped, used in FETCH
  logic [DATA_W-1:0] data_q, data_d;
  logic              dest_q, dest_d;
  logic              pop_ok, pop0, pop1;

  // Pops are gated by reset_L so nothing is popped while held in reset,
  // even though the reset state (IDLE) would otherwise allow it.
  always_comb begin
    pop0   = 1'b0;
    pop1   = 1'b0;
    pop_ok = reset_L && ((state_q == S_IDLE) || ((state_q == S_HOLD) && sink_ready));
    if (pop_ok) begin
      case ({empty_D0, empty_D1})
        2'b01:   pop0 = 1'b1;
        2'b10:   pop1 = 1'b1;
        2'b00: begin
          pop0 = last_q;
          pop1 = ~last_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    data_d  = data_q;
    dest_d  = dest_q;
    if (pop0 || pop1) begin
      sel_d  = pop1;
      last_d = pop1;
    end
    if (init) last_d = 1'b1;
    case (state_q)
      S_IDLE:  if (pop0 || pop1) state_d = S_FETCH;
      S_FETCH: begin
        data_d  = sel_q ? data_out1 : data_out0;
        dest_d  = sel_q;
        state_d = S_HOLD;
      end
      S_HOLD:  if (sink_ready) state_d = (pop0 || pop1) ? S_FETCH : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      data_q  <= '0;
      dest_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
    end
  end

  assign pop_D0     = pop0;
  assign pop_D1     = pop1;
  assign data_sink  = data_q;
  assign dest_sink  = dest_q;
  assign valid_sink = (state_q == S_HOLD);
  assign idle_drain = (state_q == S_IDLE) && empty_D0 && empty_D1;

`ifdef DRAIN_COUNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (init) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else if ((state_q == S_HOLD) && sink_ready) begin
      if (dest_q) cnt1_d = cnt1_q + 1'b1;
      else        cnt0_d = cnt0_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt_D0 = cnt0_q;
  assign cnt_D1 = cnt1_q;
`endif

endmodule

// File: tb/tb_pcie_dest_drain.sv
module tb_pcie_dest_drain;

  logic       clk;
  logic       reset_L;
  logic       init;
  logic       empty_D0, empty_D1;
  logic [5:0] data_out0, data_out1;
  logic       sink_ready;
  logic       pop_D0, pop_D1;
  logic [5:0] data_sink;
  logic       valid_sink, dest_sink, idle_drain;
`ifdef DRAIN_COUNT_EN
  logic [7:0] cnt_D0, cnt_D1;
`endif

  pcie_dest_drain #(.DATA_W(6)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .init       (init),
    .empty_D0   (empty_D0),
    .empty_D1   (empty_D1),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .sink_ready (sink_ready),
    .pop_D0     (pop_D0),
    .pop_D1     (pop_D1),
    .data_sink  (data_sink),
    .valid_sink (valid_sink),
    .dest_sink  (dest_sink),
    .idle_drain (idle_drain)
`ifdef DRAIN_COUNT_EN
    , .cnt_D0   (cnt_D0)
    , .cnt_D1   (cnt_D1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;

  // FIFO models, scoreboard of expected {dest,data}, and delivered words
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic [6:0] sb[$];
  logic [6:0] got[$];

  // values observed at the last negedge
  logic       p0_s, p1_s, vs_s, id_s, dst_s;
  logic [5:0] ds_s;

  typedef struct {
    int         n0;
    logic [5:0] w0 [4];
    int         n1;
    logic [5:0] w1 [4];
    int         ne;
    logic [6:0] ex [8];   // {dest, data}
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic upd_flags();
    empty_D0 = (q0.size() == 0);
    empty_D1 = (q1.size() == 0);
  endtask

  task automatic load(input logic [5:0] w, input logic d);
    if (d) q1.push_back(w);
    else   q0.push_back(w);
    upd_flags();
  endtask

  // One clock: observe at negedge, then apply FIFO read effects after posedge.
  task automatic step();
    logic [6:0] exp_w;
    @(negedge clk);
    p0_s = pop_D0; p1_s = pop_D1; vs_s = valid_sink; id_s = idle_drain;
    ds_s = data_sink; dst_s = dest_sink;
    if (p0_s && p1_s) chk("dual_pop", 32'd1, 32'd0);
    if (p0_s) chk("pop_D0_while_empty", {31'd0, empty_D0}, 32'd0);
    if (p1_s) chk("pop_D1_while_empty", {31'd0, empty_D1}, 32'd0);
    if (vs_s && sink_ready) begin
      got.push_back({dst_s, ds_s});
      if (sb.size() == 0) chk("sb_unexpected_word", {25'd0, dst_s, ds_s}, 32'h1ff);
      else begin
        exp_w = sb.pop_front();
        chk("sb_word", {25'd0, dst_s, ds_s}, {25'd0, exp_w});
      end
    end
    if (p0_s && q0.size() != 0) sb.push_back({1'b0, q0[0]});
    if (p1_s && q1.size() != 0) sb.push_back({1'b1, q1[0]});
    @(posedge clk);
    #1;
    if (p0_s && q0.size() != 0) data_out0 = q0.pop_front();
    if (p1_s && q1.size() != 0) data_out1 = q1.pop_front();
    upd_flags();
  endtask

  task automatic run_drain(input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", q0.size() + q1.size() + sb.size(), 32'd0);
  endtask

  task automatic pulse_init();
    init = 1'b1;
    step();
    init = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    vs_s = 1'b0;
    while (!vs_s && n < 10) begin
      step();
      n++;
    end
    chk(nm, {31'd0, vs_s}, 32'd1);
  endtask

  logic [5:0] held;
  logic       exp_p0 [6];
  logic       exp_vs [6];

  initial begin
    reset_L = 1'b0; init = 1'b0; sink_ready = 1'b0;
    data_out0 = '0; data_out1 = '0;
    upd_flags();

    tbl[0] = '{2, '{6'h15, 6'h2A, 6'h00, 6'h00}, 0, '{6'h00, 6'h00, 6'h00, 6'h00},
               2, '{7'h15, 7'h2A, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00}};
    tbl[1] = '{2, '{6'h01, 6'h02, 6'h00, 6'h00}, 2, '{6'h31, 6'h32, 6'h00, 6'h00},
               4, '{7'h01, 7'h71, 7'h02, 7'h72, 7'h00, 7'h00, 7'h00, 7'h00}};
    tbl[2] = '{0, '{6'h00, 6'h00, 6'h00, 6'h00}, 3, '{6'h07, 6'h08, 6'h09, 6'h00},
               3, '{7'h47, 7'h48, 7'h49, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00}};
    tbl[3] = '{3, '{6'h0A, 6'h0B, 6'h0C, 6'h00}, 1, '{6'h3F, 6'h00, 6'h00, 6'h00},
               4, '{7'h0A, 7'h7F, 7'h0B, 7'h0C, 7'h00, 7'h00, 7'h00, 7'h00}};
    tbl[4] = '{1, '{6'h00, 6'h00, 6'h00, 6'h00}, 2, '{6'h3F, 6'h20, 6'h00, 6'h00},
               3, '{7'h00, 7'h7F, 7'h60, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00}};
    exp_p0 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_vs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_valid", {31'd0, valid_sink}, 32'd0);
    chk("rst_data", {26'd0, data_sink}, 32'd0);
    chk("rst_dest", {31'd0, dest_sink}, 32'd0);
    chk("rst_idle", {31'd0, idle_drain}, 32'd1);
    load(6'h3C, 1'b0);
    #1;
    chk("rst_pops", {30'd0, pop_D0, pop_D1}, 32'd0);
    q0.delete(); upd_flags();
    reset_L = 1'b1;
    sink_ready = 1'b1;

    // table-driven scenarios, sink always ready
    for (int unsigned t = 0; t < 5; t++) begin
      pulse_init();
      got.delete();
      for (int i = 0; i < tbl[t].n0; i++) load(tbl[t].w0[i], 1'b0);
      for (int i = 0; i < tbl[t].n1; i++) load(tbl[t].w1[i], 1'b1);
      run_drain(40);
      chk($sformatf("tbl%0d_count", t), got.size(), tbl[t].ne);
      for (int i = 0; i < tbl[t].ne && i < got.size(); i++)
        chk($sformatf("tbl%0d_word%0d", t, i), {25'd0, got[i]}, {25'd0, tbl[t].ex[i]});
    end

    // single FIFO cycle timing
    pulse_init();
    load(6'h15, 1'b0); load(6'h2A, 1'b0);
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("single_pop0_c%0d", c), {31'd0, p0_s}, {31'd0, exp_p0[c]});
      chk($sformatf("single_pop1_c%0d", c), {31'd0, p1_s}, 32'd0);
      chk($sformatf("single_valid_c%0d", c), {31'd0, vs_s}, {31'd0, exp_vs[c]});
      if (c == 2) chk("single_data_c2", {25'd0, dst_s, ds_s}, 32'h15);
      if (c == 4) chk("single_data_c4", {25'd0, dst_s, ds_s}, 32'h2A);
    end

    // back-pressure
    pulse_init();
    sink_ready = 1'b0;
    load(6'h01, 1'b0); load(6'h02, 1'b0); load(6'h31, 1'b1); load(6'h32, 1'b1);
    wait_valid("bp_reach_hold");
    held = ds_s;
    chk("bp_first_word", {26'd0, held}, 32'h01);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("bp_nopop_c%0d", c), {30'd0, p0_s, p1_s}, 32'd0);
      chk($sformatf("bp_stable_c%0d", c), {25'd0, vs_s, ds_s}, {25'd0, 1'b1, held});
    end
    sink_ready = 1'b1;
    #1;
    chk("bp_release_pop", {30'd0, pop_D0, pop_D1}, 32'd1);
    run_drain(40);

    // empty guard
    step(); step();
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("empty_pops_c%0d", c), {30'd0, p0_s, p1_s}, 32'd0);
      chk($sformatf("empty_idle_c%0d", c), {31'd0, id_s}, 32'd1);
    end
    load(6'h2B, 1'b1);
    #1;
    chk("empty_wake_pop1", {30'd0, pop_D0, pop_D1}, 32'd1);
    chk("empty_wake_idle", {31'd0, idle_drain}, 32'd0);
    run_drain(20);

`ifdef DRAIN_COUNT_EN
    // counters
    pulse_init();
    for (int i = 0; i < 256; i++) load(6'(i), 1'b0);
    run_drain(700);
    chk("cnt_D0_wrap", {24'd0, cnt_D0}, 32'd0);
    chk("cnt_D1_zero", {24'd0, cnt_D1}, 32'd0);
    load(6'h11, 1'b1); load(6'h12, 1'b1); load(6'h13, 1'b1);
    run_drain(20);
    step();
    chk("cnt_D1_three", {24'd0, cnt_D1}, 32'd3);
    pulse_init();
    chk("cnt_D1_init", {24'd0, cnt_D1}, 32'd0);
`endif

    // reset in the middle of HOLD
    pulse_init();
    sink_ready = 1'b0;
    load(6'h11, 1'b0);
    wait_valid("rst_mid_reach_hold");
    reset_L = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, valid_sink}, 32'd0);
    chk("rst_mid_data", {26'd0, data_sink}, 32'd0);
    chk("rst_mid_dest", {31'd0, dest_sink}, 32'd0);
    q0.delete(); q1.delete(); sb.delete(); got.delete();
    load(6'h21, 1'b0); load(6'h22, 1'b1);
    #1;
    chk("rst_mid_pops", {30'd0, pop_D0, pop_D1}, 32'd0);
    step();
    chk("rst_mid_pops_held", {30'd0, p0_s, p1_s}, 32'd0);
    reset_L = 1'b1;
    sink_ready = 1'b1;
    run_drain(20);
    chk("rst_after_count", got.size(), 32'd2);
    if (got.size() == 2) begin
      chk("rst_after_first_tie", {25'd0, got[0]}, 32'h21);
      chk("rst_after_second", {25'd0, got[1]}, 32'h62);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
